// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
//   Arbitrates a read requester (time/date polling) and a write requester (time set/config)
//   onto the single multiplexed address/data RTC bus. Each granted access runs an address
//   phase then a data phase, and the block is the only driver of the RTC pins.
//   All outputs are registered and depend on state only.
//
// Ports
//   clkL, resetL            clock, asynchronous active-high reset
//   rd_req/rd_addr          read request (held until rd_ack) and register address
//   rd_ack/rd_done/rd_data  grant pulse, data-valid pulse, last read byte
//   wr_req/wr_addr/wr_data  write request (held until wr_ack), address and byte
//   wr_ack/wr_done          grant pulse, write-strobe-complete pulse
//   CS/RD/WR                active-low chip select and strobes
//   AD                      0 = address phase, 1 = data phase
//   bus_out/bus_oe/bus_in   multiplexed bus pad interface
//   busy                    high whenever not idle

module rtc_bus_sequencer #(
   parameter int unsigned PW  = 4,  // strobe low width, 1..15
   parameter int unsigned GAP = 2   // recovery cycles after each transaction, 1..15
) (
   input  logic       clkL,
   input  logic       resetL,
   input  logic       rd_req,
   input  logic [7:0] rd_addr,
   output logic       rd_ack,
   output logic       rd_done,
   output logic [7:0] rd_data,
   input  logic       wr_req,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ack,
   output logic       wr_done,
   output logic       CS,
   output logic       RD,
   output logic       WR,
   output logic       AD,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   input  logic [7:0] bus_in,
   output logic       busy
);

   typedef enum logic [2:0] {
      StIdle, StAddrSetup, StAddrStrobe, StAddrHold,
      StDataSetup, StDataStrobe, StDataHold, StRecover
   } state_e;

   localparam logic [3:0] PwCnt  = 4'(PW);
   localparam logic [3:0] GapCnt = 4'(GAP);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       op_q, op_d;      // 1 = write
   logic       last_q, last_d;  // last grant, 1 = write
   logic [7:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic       grant_wr;

   logic       cs_d, rd_d, wr_d, ad_d, oe_d, busy_d;
   logic       rd_ack_d, wr_ack_d, rd_done_d, wr_done_d;
   logic [7:0] bus_out_d;
   logic       sample_rd;

   // Leaving the last read DATA_STROBE cycle: RD is still low on this edge.
   assign sample_rd = (state_q == StDataStrobe) && (cnt_q == 4'd1) && !op_q;

   // State register and registered outputs
   always_ff @(posedge clkL or posedge resetL) begin
      if (resetL) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         op_q    <= 1'b0;
         last_q  <= 1'b0;
         addr_q  <= 8'h00;
         data_q  <= 8'h00;
         CS      <= 1'b1;
         RD      <= 1'b1;
         WR      <= 1'b1;
         AD      <= 1'b1;
         bus_oe  <= 1'b0;
         bus_out <= 8'h00;
         busy    <= 1'b0;
         rd_ack  <= 1'b0;
         wr_ack  <= 1'b0;
         rd_done <= 1'b0;
         wr_done <= 1'b0;
         rd_data <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         CS      <= cs_d;
         RD      <= rd_d;
         WR      <= wr_d;
         AD      <= ad_d;
         bus_oe  <= oe_d;
         bus_out <= bus_out_d;
         busy    <= busy_d;
         rd_ack  <= rd_ack_d;
         wr_ack  <= wr_ack_d;
         rd_done <= rd_done_d;
         wr_done <= wr_done_d;
         if (sample_rd) rd_data <= bus_in;
      end
   end

   // Next-state: arbitration in idle, phase counter elsewhere
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      last_d   = last_q;
      addr_d   = addr_q;
      data_d   = data_q;
      grant_wr = 1'b0;
      case (state_q)
         StIdle: begin
            if (rd_req || wr_req) begin
               // Round-robin on conflict: favour whoever was not granted last.
               grant_wr = wr_req && (!rd_req || !last_q);
               op_d     = grant_wr;
               last_d   = grant_wr;
               addr_d   = grant_wr ? wr_addr : rd_addr;
               data_d   = grant_wr ? wr_data : data_q;
               state_d  = StAddrSetup;
               cnt_d    = 4'd1;
            end
         end
         default: begin
            if (cnt_q > 4'd1) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               case (state_q)
                  StAddrSetup:  begin state_d = StAddrStrobe; cnt_d = PwCnt;  end
                  StAddrStrobe: begin state_d = StAddrHold;   cnt_d = 4'd1;   end
                  StAddrHold:   begin state_d = StDataSetup;  cnt_d = 4'd1;   end
                  StDataSetup:  begin state_d = StDataStrobe; cnt_d = PwCnt;  end
                  StDataStrobe: begin state_d = StDataHold;   cnt_d = 4'd1;   end
                  StDataHold:   begin state_d = StRecover;    cnt_d = GapCnt; end
                  default:      begin state_d = StIdle;       cnt_d = 4'd0;   end
               endcase
            end
         end
      endcase
   end

   // Output decode of the next state, so the pins register together with the state
   always_comb begin
      cs_d      = 1'b1;
      rd_d      = 1'b1;
      wr_d      = 1'b1;
      ad_d      = 1'b1;
      oe_d      = 1'b0;
      bus_out_d = 8'h00;
      rd_ack_d  = 1'b0;
      wr_ack_d  = 1'b0;
      rd_done_d = 1'b0;
      wr_done_d = 1'b0;
      busy_d    = (state_d != StIdle);
      case (state_d)
         StAddrSetup, StAddrStrobe, StAddrHold: begin
            cs_d      = 1'b0;
            ad_d      = 1'b0;
            oe_d      = 1'b1;
            bus_out_d = addr_d;
            wr_d      = (state_d != StAddrStrobe);  // WR latches the address in the RTC
            rd_ack_d  = (state_d == StAddrSetup) && !op_d;
            wr_ack_d  = (state_d == StAddrSetup) && op_d;
         end
         StDataSetup, StDataStrobe, StDataHold: begin
            cs_d      = 1'b0;
            oe_d      = op_d;  // read phase releases the bus before RD falls
            bus_out_d = op_d ? data_d : 8'h00;
            wr_d      = !((state_d == StDataStrobe) && op_d);
            rd_d      = !((state_d == StDataStrobe) && !op_d);
            rd_done_d = (state_d == StDataHold) && !op_d;
            wr_done_d = (state_d == StDataHold) && op_d;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Arbitrates between a read requester (periodic time/date polling) and a write requester (time set/config) for the single multiplexed address/data RTC bus.
- Sequences each granted access through a two-phase bus cycle: an address phase, then a data phase.
- Drives the active-low CS/RD/WR strobes and the AD phase select.
- Sits between the clock-display/config logic and the RTC pins, and is the only driver of those pins.

Parameters:
- PW, 4, strobe low width in clkL cycles for both phases; legal range 1..15.
- GAP, 2, recovery cycles with CS high after each transaction; legal range 1..15.

Ports:
- clkL  in  1  system clock.
- resetL  in  1  asynchronous reset, active-high.
- rd_req  in  1  read request; held high until rd_ack.
- rd_addr  in  8  RTC register address for the read.
- rd_ack  out  1  1-cycle pulse: read granted, rd_addr captured.
- rd_done  out  1  1-cycle pulse: rd_data valid.
- rd_data  out  8  last read byte; held until the next read completes.
- wr_req  in  1  write request; held high until wr_ack.
- wr_addr  in  8  RTC register address for the write.
- wr_data  in  8  byte to write.
- wr_ack  out  1  1-cycle pulse: write granted, wr_addr/wr_data captured.
- wr_done  out  1  1-cycle pulse: write strobe completed.
- CS  out  1  chip select, active-low.
- RD  out  1  read strobe, active-low.
- WR  out  1  write strobe, active-low.
- AD  out  1  0 = address phase, 1 = data phase.
- bus_out  out  8  value driven onto the multiplexed bus.
- bus_oe  out  1  bus output enable for the pad tristate.
- bus_in  in  8  multiplexed bus as seen from the pad.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered and are a function of state only (Moore).
- Reset (asynchronous, any time, including mid-transaction) forces:
  - state IDLE and counters 0;
  - CS=RD=WR=AD=1, bus_oe=0, bus_out=0x00, rd_data=0x00;
  - ack/done pulses 0, busy=0;
  - last_grant = READ, so that WRITE wins the first conflict.
- Idle pin state: CS=1, RD=1, WR=1, AD=1, bus_oe=0.
- Arbitration happens only in IDLE, at a clock edge:
  - only one request high: grant it;
  - both high: round-robin, granting the requester not in last_grant, then update last_grant.
- On grant: latch op, addr and data; go to ADDR_SETUP. The matching ack is high for exactly the ADDR_SETUP cycle.
- Requests arriving while busy wait; they are never dropped and never pre-empt.
- State sequence with cycles per state and pin values:
  - ADDR_SETUP, 1 cycle: CS=0, AD=0, bus_oe=1, bus_out=addr.
  - ADDR_STROBE, PW cycles: as ADDR_SETUP plus WR=0, which latches the address in the RTC.
  - ADDR_HOLD, 1 cycle: WR=1; CS, AD, bus_oe and addr unchanged.
  - DATA_SETUP, 1 cycle: AD=1, CS=0. Write: bus_oe=1, bus_out=data. Read: bus_oe=0.
  - DATA_STROBE, PW cycles: write drives WR=0; read drives RD=0.
  - DATA_HOLD, 1 cycle: strobes high, CS=0. Write keeps bus_oe=1. Read: rd_done=1 and rd_data updated. Write: wr_done=1.
  - RECOVER, GAP cycles: CS=1, AD=1, bus_oe=0. Then back to IDLE.
- Read sampling: bus_in is registered into rd_data on the clock edge that leaves the last DATA_STROBE cycle, while RD is still low.
- Never asserted at the same time:
  - RD and WR low together;
  - bus_oe=1 with RD low.
- Transaction length: 2*PW+4+GAP cycles in non-IDLE states (14 with defaults). At least 1 IDLE cycle sits between transactions, so the back-to-back period is 2*PW+5+GAP (15 with defaults).
- Phase counter: 4 bits; it reloads on each state entry and counts the state's cycles down to 1.

Test Plan:
- Single read: rd_addr=0x04, bus_in=0x37 during DATA_STROBE -> rd_ack on cycle 1, AD=0 for cycles 1-6, RD low cycles 8-11, rd_done on cycle 12, rd_data=0x37, busy for 14 cycles, WR low only in cycles 2-5.
- Single write: wr_addr=0x02, wr_data=0x59 -> bus_out=0x02 with WR low in cycles 2-5, then bus_out=0x59 with bus_oe=1 and WR low in cycles 8-11, RD never low, wr_done on cycle 12.
- Conflict after reset: rd_req and wr_req both held -> write granted first, read granted on the cycle after the first IDLE that follows; a third conflict grants write again (round-robin).
- Back-to-back: rd_req held high continuously -> rd_ack pulses exactly 15 cycles apart, with CS high for 3 cycles between transactions.
- Reset mid DATA_STROBE of a write: resetL pulsed -> on the same cycle CS=WR=RD=AD=1, bus_oe=0, busy=0, no wr_done; with wr_req still high after release, a full write restarts from ADDR_SETUP.
- PW=1, GAP=1 build: one read -> busy for exactly 7 cycles and RD low for exactly 1 cycle.
